// File: rtl/multicycle_controller_pkg.sv
// Shared constants for the multi-cycle MIPS control unit.
// Holds opcodes, ALUOp codes, state encodings and the control bundle.
package multicycle_controller_pkg;

    // Opcodes from the single-cycle decoder plus the extended set
    localparam logic [5:0] EXE_SPECIAL = 6'b000000;
    localparam logic [5:0] LW_OP       = 6'b100011;
    localparam logic [5:0] SW_OP       = 6'b101011;
    localparam logic [5:0] BEQ_OP      = 6'b000100;
    localparam logic [5:0] J_OP        = 6'b000010;
    localparam logic [5:0] ADDI_OP     = 6'b001000;
    localparam logic [5:0] BNE_OP      = 6'b000101;
    localparam logic [5:0] ORI_OP      = 6'b001101;
    localparam logic [5:0] ANDI_OP     = 6'b001100;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_AND   = 3'b100;

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXECUTE = 4'd6;
    localparam logic [3:0] S_ALUWB   = 4'd7;
    localparam logic [3:0] S_BRANCH  = 4'd8;
    localparam logic [3:0] S_IMMEX   = 4'd9;
    localparam logic [3:0] S_IMMWB   = 4'd10;
    localparam logic [3:0] S_JUMP    = 4'd11;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       irwrite;
        logic       pcwrite;
        logic       memwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [2:0] aluop;
        logic       zeroext;
        logic [1:0] pcsrc;
        logic       branch;
        logic       branchne;
        logic       illegal;
        logic       retire;
    } ctrl_t;

    function automatic logic op_legal(input logic [5:0] op,
                                      input logic ext);
        case (op)
            EXE_SPECIAL, LW_OP, SW_OP,
            BEQ_OP, J_OP, ADDI_OP:    op_legal = 1'b1;
            BNE_OP, ORI_OP, ANDI_OP:  op_legal = ext;
            default:                  op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Unified memory port between controller (master) and memory (slave).
// Ports: mem_req, IorD, MemWrite from master; mem_ready from slave.
interface multicycle_controller_if;
    logic mem_req;
    logic mem_ready;
    logic IorD;
    logic MemWrite;

    modport master (
        output mem_req,
        output IorD,
        output MemWrite,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  IorD,
        input  MemWrite,
        output mem_ready
    );
endinterface

// File: rtl/mc_output_decode.sv
// Combinational control-vector decode from state and latched opcode.
// In: state, op_q, opcode (DECODE legality), ready. Out: ctrl bundle.
import multicycle_controller_pkg::*;

module mc_output_decode #(
    parameter int EXT_OPS = 1
) (
    input  logic [3:0] state,
    input  logic [5:0] op_q,
    input  logic [5:0] opcode,
    input  logic       ready,
    output ctrl_t      ctrl
);
    always_comb begin
        ctrl = '0;
        unique case (state)
            S_FETCH: begin
                ctrl.mem_req = 1'b1;
                ctrl.alusrcb = 2'b01;
                ctrl.irwrite = ready;
                ctrl.pcwrite = ready;
            end
            S_DECODE: begin
                ctrl.alusrcb = 2'b11;
                // op_q is not loaded yet, so legality uses the IR field
                ctrl.illegal = !op_legal(opcode, EXT_OPS != 0);
            end
            S_MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = 2'b10;
            end
            S_MEMRD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.retire   = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_req  = 1'b1;
                ctrl.iord     = 1'b1;
                ctrl.memwrite = 1'b1;
                ctrl.retire   = ready;
            end
            S_EXECUTE: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALU_FUNCT;
            end
            S_ALUWB: begin
                ctrl.regdst   = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.retire   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alusrca  = 1'b1;
                ctrl.aluop    = ALU_SUB;
                ctrl.pcsrc    = 2'b01;
                ctrl.branch   = (op_q == BEQ_OP);
                ctrl.branchne = (op_q == BNE_OP);
                ctrl.retire   = 1'b1;
            end
            S_IMMEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = 2'b10;
                ctrl.zeroext = (op_q == ORI_OP) || (op_q == ANDI_OP);
                if (op_q == ORI_OP)
                    ctrl.aluop = ALU_OR;
                else if (op_q == ANDI_OP)
                    ctrl.aluop = ALU_AND;
                else
                    ctrl.aluop = ALU_ADD;
            end
            S_IMMWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.retire   = 1'b1;
            end
            S_JUMP: begin
                ctrl.pcsrc   = 2'b10;
                ctrl.pcwrite = 1'b1;
                ctrl.retire  = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end
endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: sequences fetch..writeback per opcode.
// Ports: clk, rst, Opcode, mem (master), datapath enables/selects, debug.
import multicycle_controller_pkg::*;

module multicycle_controller #(
    parameter int EXT_OPS = 1,
    parameter int ALUOP_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         Opcode,
    multicycle_controller_if.master mem,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic               RegWrite,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               ZeroExt,
    output logic [1:0]         PCSrc,
    output logic               Branch,
    output logic               BranchNe,
    output logic               illegal_op,
    output logic               retire,
    output logic [3:0]         state_o
);
    logic [3:0] state;
    logic [3:0] nxt;
    logic [5:0] op_q;
    logic       rst_q;
    logic       ready;
    ctrl_t      c;

    // The first FETCH cycle after reset ignores mem_ready so that no
    // write enable can fire in the cycle right after reset.
    assign ready = mem.mem_ready & ~rst_q;

    mc_output_decode #(.EXT_OPS(EXT_OPS)) u_dec (
        .state  (state),
        .op_q   (op_q),
        .opcode (Opcode),
        .ready  (ready),
        .ctrl   (c)
    );

    always_comb begin
        nxt = state;
        unique case (state)
            S_FETCH:   if (ready) nxt = S_DECODE;
            S_DECODE: begin
                if (!op_legal(Opcode, EXT_OPS != 0)) begin
                    nxt = S_FETCH;
                end else begin
                    case (Opcode)
                        EXE_SPECIAL:      nxt = S_EXECUTE;
                        LW_OP, SW_OP:     nxt = S_MEMADR;
                        BEQ_OP, BNE_OP:   nxt = S_BRANCH;
                        J_OP:             nxt = S_JUMP;
                        ADDI_OP, ORI_OP,
                        ANDI_OP:          nxt = S_IMMEX;
                        default:          nxt = S_FETCH;
                    endcase
                end
            end
            S_MEMADR:  nxt = (op_q == LW_OP) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   if (ready) nxt = S_MEMWB;
            S_MEMWR:   if (ready) nxt = S_FETCH;
            S_EXECUTE: nxt = S_ALUWB;
            S_IMMEX:   nxt = S_IMMWB;
            S_MEMWB, S_ALUWB, S_BRANCH,
            S_IMMWB, S_JUMP: nxt = S_FETCH;
            default:   nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
            op_q  <= '0;
            rst_q <= 1'b1;
        end else begin
            state <= nxt;
            rst_q <= 1'b0;
            if (state == S_DECODE)
                op_q <= Opcode;
        end
    end

    assign mem.mem_req  = c.mem_req;
    assign mem.IorD     = c.iord;
    assign mem.MemWrite = c.memwrite;
    assign IRWrite      = c.irwrite;
    assign PCWrite      = c.pcwrite;
    assign RegWrite     = c.regwrite;
    assign RegDst       = c.regdst;
    assign MemtoReg     = c.memtoreg;
    assign ALUSrcA      = c.alusrca;
    assign ALUSrcB      = c.alusrcb;
    assign ALUOp        = ALUOP_W'(c.aluop);
    assign ZeroExt      = c.zeroext;
    assign PCSrc        = c.pcsrc;
    assign Branch       = c.branch;
    assign BranchNe     = c.branchne;
    assign illegal_op   = c.illegal;
    assign retire       = c.retire;
    assign state_o      = state;
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller (EXT_OPS=1 and EXT_OPS=0).
// Both instances share clk, rst, Opcode and mem_ready.
module tb_multicycle_controller;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] Opcode = 6'd0;
    logic       mr = 1'b1;
    int         npass = 0;
    int         ntot = 0;

    always #5 clk = ~clk;

    multicycle_controller_if bus0 ();
    multicycle_controller_if bus1 ();
    assign bus0.mem_ready = mr;
    assign bus1.mem_ready = mr;

    logic       irw0, pcw0, rw0, rd0, m2r0, asa0, ze0, br0, bne0;
    logic       ill0, ret0;
    logic [1:0] asb0, pcs0;
    logic [2:0] aop0;
    logic [3:0] st0;

    logic       irw1, pcw1, rw1, rd1, m2r1, asa1, ze1, br1, bne1;
    logic       ill1, ret1;
    logic [1:0] asb1, pcs1;
    logic [2:0] aop1;
    logic [3:0] st1;

    multicycle_controller #(.EXT_OPS(1), .ALUOP_W(3)) dut0 (
        .clk(clk), .rst(rst), .Opcode(Opcode), .mem(bus0.master),
        .IRWrite(irw0), .PCWrite(pcw0), .RegWrite(rw0), .RegDst(rd0),
        .MemtoReg(m2r0), .ALUSrcA(asa0), .ALUSrcB(asb0), .ALUOp(aop0),
        .ZeroExt(ze0), .PCSrc(pcs0), .Branch(br0), .BranchNe(bne0),
        .illegal_op(ill0), .retire(ret0), .state_o(st0)
    );

    multicycle_controller #(.EXT_OPS(0), .ALUOP_W(3)) dut1 (
        .clk(clk), .rst(rst), .Opcode(Opcode), .mem(bus1.master),
        .IRWrite(irw1), .PCWrite(pcw1), .RegWrite(rw1), .RegDst(rd1),
        .MemtoReg(m2r1), .ALUSrcA(asa1), .ALUSrcB(asb1), .ALUOp(aop1),
        .ZeroExt(ze1), .PCSrc(pcs1), .Branch(br1), .BranchNe(bne1),
        .illegal_op(ill1), .retire(ret1), .state_o(st1)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        ntot++;
        if (got === exp)
            npass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in the post-reset blank FETCH cycle.
    task automatic do_reset();
        rst = 1'b1;
        mr = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
    endtask

    // Leaves the DUT in the first active FETCH cycle of op.
    task automatic start(input logic [5:0] op);
        do_reset();
        cyc();
        Opcode = op;
        mr = 1'b1;
        #1;
    endtask

    initial begin
        // reset state
        do_reset();
        chk("rst_state", st0, 0);
        chk("rst_memreq", bus0.mem_req, 1);
        chk("rst_iord", bus0.IorD, 0);
        chk("rst_irw", irw0, 0);
        chk("rst_pcw", pcw0, 0);
        chk("rst_rw", rw0, 0);
        chk("rst_memw", bus0.MemWrite, 0);
        chk("rst_ret", ret0, 0);
        chk("rst_ill", ill0, 0);

        // LW, mem_ready high
        start(6'b100011);
        chk("lw_f_st", st0, 0);
        chk("lw_f_irw", irw0, 1);
        chk("lw_f_pcw", pcw0, 1);
        chk("lw_f_asb", asb0, 2'b01);
        cyc();
        chk("lw_d_st", st0, 1);
        chk("lw_d_asb", asb0, 2'b11);
        cyc();
        chk("lw_ma_st", st0, 2);
        chk("lw_ma_asa", asa0, 1);
        chk("lw_ma_asb", asb0, 2'b10);
        cyc();
        chk("lw_mr_st", st0, 3);
        chk("lw_mr_req", bus0.mem_req, 1);
        chk("lw_mr_iord", bus0.IorD, 1);
        cyc();
        chk("lw_wb_st", st0, 4);
        chk("lw_wb_m2r", m2r0, 1);
        chk("lw_wb_rw", rw0, 1);
        chk("lw_wb_ret", ret0, 1);
        cyc();
        chk("lw_end_st", st0, 0);
        chk("lw_end_ret", ret0, 0);

        // SW with fetch wait and 2 memory wait cycles
        do_reset();
        cyc();
        Opcode = 6'b101011;
        mr = 1'b0;
        #1;
        chk("sw_fw_irw", irw0, 0);
        cyc();
        chk("sw_fw_st", st0, 0);
        mr = 1'b1;
        #1;
        chk("sw_f_irw", irw0, 1);
        cyc();
        cyc();
        chk("sw_ma_st", st0, 2);
        cyc();
        mr = 1'b0;
        #1;
        chk("sw_w1_st", st0, 5);
        chk("sw_w1_mw", bus0.MemWrite, 1);
        chk("sw_w1_ret", ret0, 0);
        cyc();
        chk("sw_w2_mw", bus0.MemWrite, 1);
        chk("sw_w2_ret", ret0, 0);
        cyc();
        mr = 1'b1;
        #1;
        chk("sw_w3_st", st0, 5);
        chk("sw_w3_mw", bus0.MemWrite, 1);
        chk("sw_w3_ret", ret0, 1);
        cyc();
        chk("sw_end_st", st0, 0);
        chk("sw_end_mw", bus0.MemWrite, 0);

        // BNE on both builds
        start(6'b000101);
        cyc();
        chk("bne_d_ill0", ill0, 0);
        chk("bne_d_ill1", ill1, 1);
        chk("bne_d_ret1", ret1, 0);
        cyc();
        chk("bne_st0", st0, 8);
        chk("bne_bne0", bne0, 1);
        chk("bne_br0", br0, 0);
        chk("bne_aop0", aop0, 3'b001);
        chk("bne_pcs0", pcs0, 2'b01);
        chk("bne_ret0", ret0, 1);
        chk("bne_st1", st1, 0);
        chk("bne_ill1", ill1, 0);

        // BEQ
        start(6'b000100);
        cyc();
        cyc();
        chk("beq_st", st0, 8);
        chk("beq_br", br0, 1);
        chk("beq_bne", bne0, 0);

        // ORI
        start(6'b001101);
        cyc();
        cyc();
        chk("ori_ex_st", st0, 9);
        chk("ori_ex_ze", ze0, 1);
        chk("ori_ex_aop", aop0, 3'b011);
        chk("ori_ex_asb", asb0, 2'b10);
        cyc();
        chk("ori_wb_st", st0, 10);
        chk("ori_wb_rw", rw0, 1);
        chk("ori_wb_rd", rd0, 0);
        chk("ori_wb_ret", ret0, 1);

        // ANDI and ADDI immediate handling
        start(6'b001100);
        cyc();
        cyc();
        chk("andi_aop", aop0, 3'b100);
        chk("andi_ze", ze0, 1);
        start(6'b001000);
        cyc();
        cyc();
        chk("addi_aop", aop0, 3'b000);
        chk("addi_ze", ze0, 0);

        // R-type
        start(6'b000000);
        cyc();
        cyc();
        chk("r_ex_st", st0, 6);
        chk("r_ex_aop", aop0, 3'b010);
        cyc();
        chk("r_wb_rd", rd0, 1);
        chk("r_wb_ret", ret0, 1);
        cyc();
        chk("r_end_st", st0, 0);

        // J
        start(6'b000010);
        cyc();
        cyc();
        chk("j_st", st0, 11);
        chk("j_pcs", pcs0, 2'b10);
        chk("j_pcw", pcw0, 1);
        chk("j_ret", ret0, 1);

        // illegal opcode
        start(6'b111111);
        cyc();
        chk("ill_d_ill", ill0, 1);
        chk("ill_d_ret", ret0, 0);
        chk("ill_d_rw", rw0, 0);
        chk("ill_d_mw", bus0.MemWrite, 0);
        chk("ill_d_pcw", pcw0, 0);
        cyc();
        chk("ill_end_st", st0, 0);
        chk("ill_end_ill", ill0, 0);

        // reset mid-MEMRD
        start(6'b100011);
        cyc();
        cyc();
        cyc();
        mr = 1'b0;
        #1;
        cyc();
        chk("rmr_hold_st", st0, 3);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        mr = 1'b1;
        #1;
        chk("rmr_st", st0, 0);
        chk("rmr_req", bus0.mem_req, 1);
        chk("rmr_iord", bus0.IorD, 0);
        chk("rmr_irw", irw0, 0);
        chk("rmr_pcw", pcw0, 0);
        chk("rmr_rw", rw0, 0);
        chk("rmr_mw", bus0.MemWrite, 0);
        chk("rmr_ret", ret0, 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Parametrised multi-cycle control unit for the MIPS core, following the single-cycle opcode decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states over a shared ALU and a unified memory port. It also adds a memory ready handshake, optional extended opcodes and illegal-opcode reporting. It sits between the instruction register and the datapath multiplexers, register file and memory interface.

## Interface
- `EXT_OPS`, default 1: 1 enables BNE/ORI/ANDI; 0 treats them as illegal.
- `ALUOP_W`, default 3: ALUOp width; must be ≥3.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `Opcode` in 6: IR[31:26]; valid from DECODE onward, held by IR.
- `mem_ready` in 1: memory completes the current access this cycle.
- `mem_req` out 1: memory access requested (FETCH, MEMRD, MEMWR).
- `IorD` out 1: 0 = PC address, 1 = ALUOut address.
- `IRWrite`, `PCWrite`, `MemWrite`, `RegWrite` out 1 each: write enables.
- `RegDst`, `MemtoReg` out 1 each: writeback select (rd vs rt, mem vs ALUOut).
- `ALUSrcA` out 1: 0 = PC, 1 = rs.
- `ALUSrcB` out 2: 00 = rt, 01 = const 4, 10 = imm, 11 = imm<<2.
- `ALUOp` out ALUOP_W: 000 add, 001 sub, 010 funct, 011 or, 100 and.
- `ZeroExt` out 1: immediate zero-extended (ORI/ANDI), else sign-extended.
- `PCSrc` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `Branch`, `BranchNe` out 1 each: conditional PC write on zero / not-zero.
- `illegal_op` out 1: one-cycle pulse on an unsupported opcode.
- `retire` out 1: one-cycle pulse in the final state of each instruction.
- `state_o` out 4: current state encoding, for debug.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, IMMEX, IMMWB, JUMP.
- Outputs are Moore-decoded from state and registered opcode `op_q`. Exception: IRWrite and PCWrite in FETCH are gated by `mem_ready`.
- **FETCH**
  - Drives mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=add, PCSrc=00.
  - Holds until mem_ready=1, then asserts IRWrite and PCWrite that cycle and moves to DECODE.
- **DECODE**
  - Drives ALUSrcA=0, ALUSrcB=11, ALUOp=add.
  - Latches Opcode into op_q.
  - Next state by opcode:
    - 000000 → EXECUTE
    - 100011 / 101011 → MEMADR
    - 000100 → BRANCH
    - 000010 → JUMP
    - 001000 → IMMEX
    - when EXT_OPS=1: 000101 → BRANCH; 001101 / 001100 → IMMEX
    - anything else → FETCH with illegal_op=1
- **MEMADR**: ALUSrcA=1, ALUSrcB=10, add. Goes to MEMRD if op_q=LW, else MEMWR.
- **MEMRD**: mem_req=1, IorD=1. Holds until mem_ready, then MEMWB.
- **MEMWB**: RegDst=0, MemtoReg=1, RegWrite=1, retire. Then FETCH.
- **MEMWR**: mem_req=1, IorD=1, MemWrite=1. Holds until mem_ready; on mem_ready asserts retire and returns to FETCH.
- **EXECUTE**: ALUSrcA=1, ALUSrcB=00, ALUOp=funct. Then ALUWB.
- **ALUWB**: RegDst=1, MemtoReg=0, RegWrite=1, retire. Then FETCH.
- **BRANCH**: ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01, retire. Branch=1 for BEQ; BranchNe=1 for BNE. Then FETCH.
- **IMMEX**: ALUSrcA=1, ALUSrcB=10. ALUOp is add (ADDI), or (ORI), or and (ANDI). ZeroExt=1 for ORI/ANDI. Then IMMWB.
- **IMMWB**: RegDst=0, MemtoReg=0, RegWrite=1, retire. Then FETCH.
- **JUMP**: PCSrc=10, PCWrite=1, retire. Then FETCH.
- Any output not listed for a state is 0.

## Timing
- Reset: state=FETCH and op_q=0.
  - All write enables, illegal_op and retire are 0.
  - mem_req=1, because the FETCH decode is active immediately after reset.
- rst takes priority over every transition.
  - rst during MEMWR deasserts MemWrite next cycle.
  - No write enable asserts in the cycle following reset.
- Latency with mem_ready tied high:
  - R-type 4 cycles, LW 5, SW 4, BEQ/BNE 3, J 3, ADDI/ORI/ANDI 4.
  - Illegal opcode 2 cycles.
- Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds one cycle. Outputs are held stable while waiting.
- mem_ready outside memory states is ignored.
- Exactly one retire per legal instruction. illegal_op and retire are never asserted together.

## Structure
- A shared package (extending `define.v`) holds:
  - opcode constants: existing EXE_SPECIAL, LW_OP, SW_OP, BEQ_OP, J_OP, ADDI_OP, plus new BNE_OP, ORI_OP, ANDI_OP;
  - ALUOp codes;
  - state encodings.
- Sub-module `mc_output_decode` is the combinational state/op_q to control-vector decode. The FSM and op_q register stay in the top module.

## Test plan
- **LW, mem_ready tied high**: Opcode=100011 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB. MemtoReg=RegWrite=1 in cycle 5; retire in cycle 5.
- **SW with memory wait**: Opcode=101011, mem_ready low for 2 cycles in MEMWR → MemWrite high for 3 cycles; retire on the third, with mem_ready.
- **BNE**: with EXT_OPS=1, Opcode=000101 → BRANCH with BranchNe=1, Branch=0, ALUOp=001. With EXT_OPS=0 → illegal_op pulse in DECODE, then FETCH.
- **ORI**: Opcode=001101 → IMMEX with ZeroExt=1, ALUOp=011, ALUSrcB=10; then IMMWB with RegWrite=1, RegDst=0.
- **Illegal opcode**: Opcode=111111 → illegal_op for 1 cycle; no RegWrite, MemWrite or PCWrite beyond FETCH.
- **Reset mid-MEMRD**: rst=1 for 1 cycle → next cycle state=FETCH, mem_req=1, IorD=0, all write enables 0, retire 0.
